pack_sum: RTL and testbench

//  Final stage of the FP add/sub pipeline, directly downstream of NormaliseSum.

---
 rtl/pack_sum_pkg.sv | 37 +++
 rtl/pack_sum_round_rne.sv | 22 ++
 rtl/pack_sum.sv | 141 ++++++++++++++
 tb/tb_pack_sum.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pack_sum_pkg.sv
// Shared constants and types for the FP add/sub pack stage and its rounding helper.
package pack_sum_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MIN  = -126;

  // Guard / round / sticky positions inside the 3-bit tail of the sum.
  localparam int G_BIT = 2;
  localparam int R_BIT = 1;
  localparam int S_BIT = 0;

  typedef enum logic [1:0] {
    NO_IDLE     = 2'b00,
    ALLIGN_IDLE = 2'b01,
    PUT_IDLE    = 2'b10
  } idle_e;

  typedef enum logic [1:0] {
    MODE_CIRCULAR   = 2'b00,
    MODE_LINEAR     = 2'b01,
    MODE_HYPERBOLIC = 2'b10
  } mode_e;

  // One beat held between the round stage and the pack stage.
  typedef struct packed {
    logic        sign;
    logic [9:0]  expVal;   // unbiased, two's complement
    logic [23:0] mant;     // rounded mantissa incl. hidden bit
    logic [1:0]  idle;
    logic [31:0] soutRaw;  // untouched input word for the bypass path
    logic [1:0]  mode;
    logic        operation;
    logic        natLog;
    logic [7:0]  insTag;
  } round_beat_t;

endpackage

// File: rtl/pack_sum_round_rne.sv
// Round-to-nearest-even on a 24-bit mantissa with a G/R/S tail; shared with the multiply path.
module round_rne
  import pack_sum_pkg::*;
(
  input  logic [23:0] mantIn,
  input  logic [2:0]  grsIn,
  output logic [23:0] mantOut,
  output logic        carryOut
);

  logic        roundUp;
  logic [24:0] mantSum;

  // Increment when above half-ulp, or exactly half and the mantissa is odd.
  always_comb begin
    roundUp  = grsIn[G_BIT] & (grsIn[R_BIT] | grsIn[S_BIT] | mantIn[0]);
    mantSum  = {1'b0, mantIn} + {24'd0, roundUp};
    mantOut  = mantSum[23:0];
    carryOut = mantSum[24];
  end

endmodule

// File: rtl/pack_sum.sv
// Final FP add/sub stage: round (stage 1) then IEEE-754 single pack (stage 2),
// with valid/ready backpressure and sideband fields carried alongside each beat.
module pack_sum
  import pack_sum_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  idle_NormaliseSum,
  input  logic [31:0] sout_NormaliseSum,
  input  logic [1:0]  modeout_NormaliseSum,
  input  logic        operationout_NormaliseSum,
  input  logic        NatLogFlagout_NormaliseSum,
  input  logic [27:0] sum_NormaliseSum,
  input  logic [7:0]  InsTag_NormaliseSum,
  input  logic        valid_NormaliseSum,
  output logic        ready_PackSum,
  output logic [1:0]  idle_PackSum,
  output logic [1:0]  modeout_PackSum,
  output logic        operationout_PackSum,
  output logic        NatLogFlagout_PackSum,
  output logic [7:0]  InsTag_PackSum,
  output logic [31:0] sout_PackSum,
  output logic        valid_PackSum,
  input  logic        ready_Downstream
);

  localparam logic signed [9:0] ExpMin  = 10'(EXP_MIN);
  localparam logic signed [9:0] ExpBias = 10'(EXP_BIAS);

  logic              adv1, adv2, v1;
  logic signed [9:0] expIn, expPre, biasedExp;
  logic [9:0]        shiftAmt;
  logic [26:0]       grsFull, shifted, shiftMask;
  logic [23:0]       mantPre, mantRnd;
  logic [2:0]        grsPre;
  logic              roundCarry;
  logic [31:0]       packedSout;
  logic              unusedSumMsb;
  round_beat_t       s1d, s1q;

  // Bit 27 of the normalised sum is always zero upstream.
  assign unusedSumMsb = sum_NormaliseSum[27];

  assign adv2          = !valid_PackSum | ready_Downstream;
  assign adv1          = !v1 | adv2;
  assign ready_PackSum = adv1;

  // Denormalise below EXP_MIN, folding every shifted-out bit into sticky.
  always_comb begin
    expIn     = {{2{sout_NormaliseSum[30]}}, sout_NormaliseSum[30:23]};
    grsFull   = sum_NormaliseSum[26:0];
    mantPre   = sum_NormaliseSum[26:3];
    grsPre    = sum_NormaliseSum[2:0];
    expPre    = expIn;
    shiftAmt  = '0;
    shifted   = grsFull;
    shiftMask = '0;
    if (expIn < ExpMin) begin
      shiftAmt = ExpMin - expIn;
      expPre   = ExpMin;
      if (shiftAmt >= 10'd26) begin
        mantPre = '0;
        grsPre  = '0;
      end else begin
        shiftMask = (27'd1 << shiftAmt) - 27'd1;
        shifted   = grsFull >> shiftAmt;
        mantPre   = shifted[26:3];
        grsPre    = {shifted[2:1], shifted[0] | (|(grsFull & shiftMask))};
      end
    end
  end

  round_rne uRound (
    .mantIn   (mantPre),
    .grsIn    (grsPre),
    .mantOut  (mantRnd),
    .carryOut (roundCarry)
  );

  // Renormalise on rounding carry and bundle the beat for stage 1.
  always_comb begin
    s1d           = '0;
    s1d.sign      = sout_NormaliseSum[31];
    s1d.expVal    = roundCarry ? expPre + 10'sd1 : expPre;
    s1d.mant      = roundCarry ? {1'b1, mantRnd[23:1]} : mantRnd;
    s1d.idle      = idle_NormaliseSum;
    s1d.soutRaw   = sout_NormaliseSum;
    s1d.mode      = modeout_NormaliseSum;
    s1d.operation = operationout_NormaliseSum;
    s1d.natLog    = NatLogFlagout_NormaliseSum;
    s1d.insTag    = InsTag_NormaliseSum;
  end

  // Stage 1 register: accepts a new beat whenever it is empty or draining.
  always_ff @(posedge clock) begin
    if (reset) begin
      v1  <= 1'b0;
      s1q <= '0;
    end else if (adv1) begin
      v1  <= valid_NormaliseSum;
      s1q <= s1d;
    end
  end

  // Pack into IEEE single: zero, denormal, infinity, normal, or raw bypass.
  always_comb begin
    biasedExp = $signed(s1q.expVal) + ExpBias;
    if (s1q.idle == PUT_IDLE)
      packedSout = s1q.soutRaw;
    else if (s1q.mant == 24'd0)
      packedSout = {s1q.sign, 31'h0};
    else if (!s1q.mant[23])
      packedSout = {s1q.sign, 8'h00, s1q.mant[22:0]};
    else if (biasedExp >= 10'sd255)
      packedSout = {s1q.sign, 8'hFF, 23'h0};
    else
      packedSout = {s1q.sign, biasedExp[7:0], s1q.mant[22:0]};
  end

  // Stage 2 / output register: holds the beat while downstream stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_PackSum         <= 1'b0;
      sout_PackSum          <= '0;
      idle_PackSum          <= '0;
      modeout_PackSum       <= '0;
      operationout_PackSum  <= 1'b0;
      NatLogFlagout_PackSum <= 1'b0;
      InsTag_PackSum        <= '0;
    end else if (adv2) begin
      valid_PackSum         <= v1;
      sout_PackSum          <= packedSout;
      idle_PackSum          <= s1q.idle;
      modeout_PackSum       <= s1q.mode;
      operationout_PackSum  <= s1q.operation;
      NatLogFlagout_PackSum <= s1q.natLog;
      InsTag_PackSum        <= s1q.insTag;
    end
  end

endmodule

// File: tb/tb_pack_sum.sv
// Bench for pack_sum: directed IEEE cases, backpressure/reset, then random traffic
// checked against an exact-arithmetic rounding model and an in-order scoreboard.
module tb_pack_sum;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  idle_NormaliseSum;
  logic [31:0] sout_NormaliseSum;
  logic [1:0]  modeout_NormaliseSum;
  logic        operationout_NormaliseSum;
  logic        NatLogFlagout_NormaliseSum;
  logic [27:0] sum_NormaliseSum;
  logic [7:0]  InsTag_NormaliseSum;
  logic        valid_NormaliseSum;
  logic        ready_PackSum;
  logic [1:0]  idle_PackSum;
  logic [1:0]  modeout_PackSum;
  logic        operationout_PackSum;
  logic        NatLogFlagout_PackSum;
  logic [7:0]  InsTag_PackSum;
  logic [31:0] sout_PackSum;
  logic        valid_PackSum;
  logic        ready_Downstream;

  typedef struct packed {
    logic [31:0] sout;
    logic [1:0]  idle;
    logic [1:0]  mode;
    logic        op;
    logic        nat;
    logic [7:0]  tag;
  } beat_t;

  beat_t       expQ[$];
  beat_t       gotBeat, wantBeat, heldBeat;
  logic        holdFlag = 1'b0;
  logic        litValid;
  logic [31:0] litSout;
  logic        doneSending;
  int          nChecks = 0;
  int          nPass = 0;

  always #5 clock = ~clock;

  pack_sum dut (
    .clock                      (clock),
    .reset                      (reset),
    .idle_NormaliseSum          (idle_NormaliseSum),
    .sout_NormaliseSum          (sout_NormaliseSum),
    .modeout_NormaliseSum       (modeout_NormaliseSum),
    .operationout_NormaliseSum  (operationout_NormaliseSum),
    .NatLogFlagout_NormaliseSum (NatLogFlagout_NormaliseSum),
    .sum_NormaliseSum           (sum_NormaliseSum),
    .InsTag_NormaliseSum        (InsTag_NormaliseSum),
    .valid_NormaliseSum         (valid_NormaliseSum),
    .ready_PackSum              (ready_PackSum),
    .idle_PackSum               (idle_PackSum),
    .modeout_PackSum            (modeout_PackSum),
    .operationout_PackSum       (operationout_PackSum),
    .NatLogFlagout_PackSum      (NatLogFlagout_PackSum),
    .InsTag_PackSum             (InsTag_PackSum),
    .sout_PackSum               (sout_PackSum),
    .valid_PackSum              (valid_PackSum),
    .ready_Downstream           (ready_Downstream)
  );

  task automatic checkVal(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    if (observed === expected) nPass++;
    else $display("FAIL %s: observed %0h required %0h", tag, observed, expected);
  endtask

  // Exact-value round-to-nearest-even: the 27-bit field is an integer scaled by
  // 2^(e-26); drop enough low bits to land on a 24-bit mantissa at exponent >= -126.
  function automatic logic [31:0] refPack(input logic [31:0] s, input logic [27:0] sm);
    int     e, sh;
    longint x, q, rem, half;
    e  = int'($signed(s[30:23]));
    x  = longint'(sm[26:0]);
    sh = 3;
    if (e < -126) begin
      sh = 3 + (-126 - e);
      e  = -126;
    end
    q    = x >> sh;
    rem  = x - (q << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && q[0] == 1'b1)) q = q + 1;
    if (q >= (longint'(1) << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (q == 0) return {s[31], 31'h0};
    if (q < (longint'(1) << 23)) return {s[31], 8'h00, q[22:0]};
    if (e + 127 >= 255) return {s[31], 8'hFF, 23'h0};
    return {s[31], 8'(e + 127), q[22:0]};
  endfunction

  function automatic beat_t refBeat();
    beat_t b;
    b.sout = (idle_NormaliseSum == 2'b10) ? sout_NormaliseSum
                                          : refPack(sout_NormaliseSum, sum_NormaliseSum);
    b.idle = idle_NormaliseSum;
    b.mode = modeout_NormaliseSum;
    b.op   = operationout_NormaliseSum;
    b.nat  = NatLogFlagout_NormaliseSum;
    b.tag  = InsTag_NormaliseSum;
    return b;
  endfunction

  // Scoreboard: record accepted beats, check emitted beats in order, check held stability.
  always @(negedge clock) begin
    gotBeat = {sout_PackSum, idle_PackSum, modeout_PackSum, operationout_PackSum,
               NatLogFlagout_PackSum, InsTag_PackSum};
    if (reset) begin
      expQ.delete();
      holdFlag = 1'b0;
    end else begin
      if (holdFlag) checkVal("held", {valid_PackSum, gotBeat}, {1'b1, heldBeat});
      if (valid_PackSum && ready_Downstream) begin
        checkVal("expected_beat", 64'(expQ.size() > 0), 1);
        if (expQ.size() > 0) begin
          wantBeat = expQ.pop_front();
          checkVal("sout", gotBeat.sout, wantBeat.sout);
          checkVal("sideband", {gotBeat.idle, gotBeat.mode, gotBeat.op, gotBeat.nat, gotBeat.tag},
                   {wantBeat.idle, wantBeat.mode, wantBeat.op, wantBeat.nat, wantBeat.tag});
        end
      end
      holdFlag = valid_PackSum && !ready_Downstream;
      heldBeat = gotBeat;
      if (valid_NormaliseSum && ready_PackSum) begin
        wantBeat = refBeat();
        if (litValid) wantBeat.sout = litSout;
        expQ.push_back(wantBeat);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
  task automatic sendBeat(input logic [1:0] idle, input logic [31:0] sout, input logic [27:0] sm,
                          input logic [7:0] tag, input logic lit, input logic [31:0] litS);
    logic accepted;
    idle_NormaliseSum          = idle;
    sout_NormaliseSum          = sout;
    sum_NormaliseSum           = sm;
    InsTag_NormaliseSum        = tag;
    modeout_NormaliseSum       = 2'($urandom_range(0, 2));
    operationout_NormaliseSum  = 1'($urandom);
    NatLogFlagout_NormaliseSum = 1'($urandom);
    litValid                   = lit;
    litSout                    = litS;
    valid_NormaliseSum         = 1'b1;
    accepted                   = 1'b0;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clock);
      if (ready_PackSum) accepted = 1'b1;
      @(posedge clock);
      #1;
    end
    valid_NormaliseSum = 1'b0;
    litValid           = 1'b0;
    checkVal("accept", 64'(accepted), 1);
  endtask

  task automatic sendRandom(input logic [7:0] tag);
    logic [7:0]  ex;
    logic [23:0] m;
    logic [1:0]  idle;
    ex = 8'($urandom);
    if ($urandom_range(0, 3) == 0) ex = 8'($urandom_range(8'h7C, 8'h86));
    m = {1'b1, 23'($urandom)};
    if ($urandom_range(0, 7) == 0) m = 24'hFFFFFF;
    idle = 2'($urandom_range(0, 2));
    if (idle == 2'b10)
      sendBeat(idle, $urandom, 28'($urandom), tag, 1'b0, 32'h0);
    else
      sendBeat(idle, {1'($urandom), ex, 23'($urandom)},
               {1'b0, m, 3'($urandom_range(0, 7))}, tag, 1'b0, 32'h0);
  endtask

  task automatic drain();
    ready_Downstream = 1'b1;
    for (int i = 0; i < 100 && expQ.size() != 0; i++) @(posedge clock);
    #1;
    checkVal("drain", 64'(expQ.size()), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1);
  end

  initial begin
    reset                      = 1'b1;
    idle_NormaliseSum          = '0;
    sout_NormaliseSum          = '0;
    modeout_NormaliseSum       = '0;
    operationout_NormaliseSum  = 1'b0;
    NatLogFlagout_NormaliseSum = 1'b0;
    sum_NormaliseSum           = '0;
    InsTag_NormaliseSum        = '0;
    valid_NormaliseSum         = 1'b0;
    ready_Downstream           = 1'b1;
    litValid                   = 1'b0;
    litSout                    = '0;
    doneSending                = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkVal("rst_valid", 64'(valid_PackSum), 0);
    checkVal("rst_sout", sout_PackSum, 0);
    checkVal("rst_tag", InsTag_PackSum, 0);
    reset = 1'b0;
    checkVal("rst_ready", 64'(ready_PackSum), 1);

    // 1.0 and two-cycle latency
    sendBeat(2'b00, 32'h0, {1'b0, 24'h800000, 3'b000}, 8'h11, 1'b1, 32'h3F800000);
    @(negedge clock);
    checkVal("latency_c1", 64'(valid_PackSum), 0);
    @(negedge clock);
    checkVal("latency_c2", 64'(valid_PackSum), 1);
    @(posedge clock);
    #1;

    // Tie-to-even, carry, overflow, denormal, underflow, bypass
    sendBeat(2'b00, 32'h0, {1'b0, 24'h800001, 3'b100}, 8'h21, 1'b1, 32'h3F800002);
    sendBeat(2'b00, 32'h0, {1'b0, 24'h800000, 3'b100}, 8'h22, 1'b1, 32'h3F800000);
    sendBeat(2'b00, {1'b0, 8'h7F, 23'h0}, {1'b0, 24'hFFFFFF, 3'b110}, 8'h31, 1'b1, 32'h7F800000);
    sendBeat(2'b00, 32'h0, {1'b0, 24'hFFFFFF, 3'b110}, 8'h32, 1'b1, 32'h40000000);
    sendBeat(2'b00, {1'b0, 8'h82, 23'h0}, {1'b0, 24'h400000, 3'b000}, 8'h41, 1'b1, 32'h00400000);
    sendBeat(2'b00, {1'b1, 8'h80, 23'h0}, {1'b0, 24'h000001, 3'b000}, 8'h42, 1'b1, 32'h80000000);
    sendBeat(2'b00, {1'b0, 8'h80, 23'h0}, {1'b0, 24'h800000, 3'b000}, 8'h43, 1'b1, 32'h00200000);
    sendBeat(2'b10, 32'h7FC00000, 28'h0, 8'h51, 1'b1, 32'h7FC00000);
    drain();

    // Four back-to-back beats with a three-cycle downstream stall
    fork
      begin
        for (int t = 1; t <= 4; t++) sendRandom(8'(t));
      end
      begin
        repeat (2) @(posedge clock);
        #1 ready_Downstream = 1'b0;
        repeat (3) @(posedge clock);
        #1 ready_Downstream = 1'b1;
      end
    join
    drain();

    // Reset with beats in flight: nothing may emerge afterwards
    ready_Downstream = 1'b0;
    sendRandom(8'h61);
    sendRandom(8'h62);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset            = 1'b0;
    ready_Downstream = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkVal("post_rst_valid", 64'(valid_PackSum), 0);
      checkVal("post_rst_ready", 64'(ready_PackSum), 1);
    end
    @(posedge clock);
    #1;
    sendRandom(8'h63);
    drain();

    // Random traffic with random downstream stalls
    fork
      begin
        for (int t = 0; t < 300; t++) begin
          sendRandom(8'(t));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clock);
            #1;
          end
        end
        doneSending = 1'b1;
      end
      begin
        while (!doneSending) begin
          @(posedge clock);
          #1 ready_Downstream = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
